// File: rtl/hue_pkg.sv
// hue_pkg: shared widths, channel slices and segment codes for the hue wheel decoder.
// Revision: 1.0
`default_nettype none
package hue_pkg;
  localparam int LOC_W   = 10;
  localparam int COLOR_W = 24;
  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;
  localparam logic [7:0] CH_MAX = 8'hFF;

  typedef enum logic [1:0] {
    SEG_GR = 2'b00,
    SEG_RB = 2'b01,
    SEG_BG = 2'b10
  } seg_e;
endpackage
`default_nettype wire

// File: rtl/hue_decode_if.sv
// hue_decode_if: colour-in / location-out valid-ready stream bundle.
// Revision: 1.0
`default_nettype none
interface hue_decode_if;
  import hue_pkg::*;
  logic               in_valid;
  logic               in_ready;
  logic [COLOR_W-1:0] in_color;
  logic               out_valid;
  logic               out_ready;
  logic [LOC_W-1:0]   out_loc;
  logic               out_err;

  modport slave (
    input  in_valid, in_color, out_ready,
    output in_ready, out_valid, out_loc, out_err
  );
  modport master (
    output in_valid, in_color, out_ready,
    input  in_ready, out_valid, out_loc, out_err
  );
endinterface
`default_nettype wire

// File: rtl/hue_seg_match.sv
// hue_seg_match: one wheel segment matches when its zero channel is 0 and the other two sum to 255.
// Revision: 1.0
`default_nettype none
module hue_seg_match
  import hue_pkg::*;
(
  input  logic [7:0] zc,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       match
);
  logic [8:0] sum;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign match = (zc == 8'h00) && (sum == {1'b0, CH_MAX});
endmodule
`default_nettype wire

// File: rtl/hue_decode.sv
// hue_decode: two-stage colour-to-hue-location decoder with off-wheel flag and error counter.
// Revision: 1.0
`default_nettype none
module hue_decode
  import hue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hue_decode_if.slave      bus,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);
  logic [7:0]         in_g, in_r, in_b;
  logic [2:0]         match;
  logic               advance, s1_load;
  logic               s1_valid;
  logic [COLOR_W-1:0] s1_color;
  logic [2:0]         s1_match;
  logic               s2_valid;
  logic [LOC_W-1:0]   s2_loc;
  logic               s2_err;
  logic [LOC_W-1:0]   dec_loc;
  logic               dec_err;
  logic               err_leave;

  assign in_g = bus.in_color[G_HI:G_LO];
  assign in_r = bus.in_color[R_HI:R_LO];
  assign in_b = bus.in_color[B_HI:B_LO];

  hue_seg_match u_match_gr (.zc(in_b), .a(in_g), .b(in_r), .match(match[0]));
  hue_seg_match u_match_rb (.zc(in_g), .a(in_r), .b(in_b), .match(match[1]));
  hue_seg_match u_match_bg (.zc(in_r), .a(in_g), .b(in_b), .match(match[2]));

  assign advance      = bus.out_ready | ~s2_valid;
  assign s1_load      = advance | ~s1_valid;
  assign bus.in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_color <= '0;
      s1_match <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_color <= bus.in_color;
        s1_match <= match;
      end
    end
  end

  // Priority order resolves the shared corners to the lowest location.
  always_comb begin
    dec_loc = '0;
    dec_err = 1'b0;
    if (s1_match[0])      dec_loc = {SEG_GR, s1_color[R_HI:R_LO]};
    else if (s1_match[1]) dec_loc = {SEG_RB, s1_color[B_HI:B_LO]};
    else if (s1_match[2]) dec_loc = {SEG_BG, s1_color[G_HI:G_LO]};
    else                  dec_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_loc   <= '0;
      s2_err   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_loc <= dec_loc;
        s2_err <= dec_err;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_loc   = s2_loc;
  assign bus.out_err   = s2_err;

  assign err_leave = s2_valid & bus.out_ready & s2_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_leave && !(&err_cnt)) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hue_decode.sv
// tb_hue_decode: randomized scoreboard bench for hue_decode against a rule-level reference model.
// Revision: 1.0
`default_nettype none
module tb_hue_decode;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;
  logic             rand_bp = 1'b0;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [10:0] exp_q[$];

  hue_decode_if bus();

  hue_decode #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // {err, loc} straight from the wheel rules, evaluated with integer arithmetic.
  function automatic logic [10:0] ref_decode(input logic [23:0] c);
    int g, r, b;
    g = int'(c[23:16]);
    r = int'(c[15:8]);
    b = int'(c[7:0]);
    if (b == 0 && g + r == 255) return {1'b0, 2'd0, 8'(r)};
    if (g == 0 && r + b == 255) return {1'b0, 2'd1, 8'(b)};
    if (r == 0 && g + b == 255) return {1'b0, 2'd2, 8'(g)};
    return {1'b1, 10'h000};
  endfunction

  function automatic logic [23:0] encode(input int loc);
    int seg, off, g, r, b;
    seg = (loc / 256) % 4;
    off = loc % 256;
    case (seg)
      1:       begin g = 0;         r = 255 - off; b = off;       end
      2:       begin g = off;       r = 0;         b = 255 - off; end
      default: begin g = 255 - off; r = off;       b = 0;         end
    endcase
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  task automatic send(input logic [23:0] c);
    int  n;
    logic ok;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_color = c;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok) begin
        exp_q.push_back(ref_decode(c));
        break;
      end
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout color=%06h in_ready never high", c);
        break;
      end
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin : monitor
    logic        held;
    logic [10:0] held_v;
    logic [10:0] e;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_cnt = 0;
        held = 1'b0;
        continue;
      end
      if (held) begin
        checks++;
        if (!bus.out_valid || {bus.out_err, bus.out_loc} !== held_v) begin
          errors++;
          $display("FAIL stall_hold actual=%b/%03h required=1/%03h", bus.out_valid,
                   {bus.out_err, bus.out_loc}, held_v);
        end
      end
      held   = bus.out_valid && !bus.out_ready;
      held_v = {bus.out_err, bus.out_loc};
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%03h required=none", {bus.out_err, bus.out_loc});
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_err, bus.out_loc} !== e) begin
            errors++;
            $display("FAIL result actual=err%b loc%03h required=err%b loc%03h",
                     bus.out_err, bus.out_loc, e[10], e[9:0]);
          end
        end
        checks++;
        if (int'(err_cnt) != model_cnt) begin
          errors++;
          $display("FAIL err_cnt_track actual=%0d required=%0d", err_cnt, model_cnt);
        end
        if (err_clr) model_cnt = 0;
        else if (bus.out_err && model_cnt < CNT_MAX) model_cnt++;
      end else if (err_clr) begin
        model_cnt = 0;
      end
    end
  end

  initial begin : bp_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : stim
    logic [23:0] corners[5];
    logic [23:0] offw[4];
    logic        saw_stall;
    corners = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h80007F, 24'h7F8000};
    offw    = '{24'h000000, 24'hFFFFFF, 24'h808000, 24'h010101};
    bus.in_valid  = 1'b0;
    bus.in_color  = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_loc", int'(bus.out_loc), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 1024; i++) send(encode(i));
    drain();
    check("sweep_err_cnt", int'(err_cnt), 0);
    check("sweep_boundary_100", int'(ref_decode(encode(12'h100))), 11'h0FF);

    foreach (corners[i]) send(corners[i]);
    drain();

    foreach (offw[i]) send(offw[i]);
    drain();
    check("offwheel_err_cnt", int'(err_cnt), 4);

    for (int i = 0; i < 20; i++) send(offw[i % 4]);
    drain();
    check("sat_err_cnt", int'(err_cnt), CNT_MAX);

    bus.out_ready = 1'b0;
    send(24'h010101);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    err_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("clr_priority_err_cnt", int'(err_cnt), 0);
    check("clr_beat_taken", exp_q.size(), 0);

    rand_bp = 1'b1;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0:       send(24'($urandom));
        1:       send(corners[$urandom_range(0, 4)]);
        default: send(encode(int'($urandom_range(0, 1023))));
      endcase
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(encode(int'($urandom_range(0, 767))));
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!bus.in_ready) saw_stall = 1'b1;
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_dropped", int'(saw_stall), 1);

    rand_bp = 1'b1;
    for (int i = 0; i < 10; i++) send(24'($urandom) | 24'h010101);
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    bus.out_ready = 1'b0;
    send(encode(12'h042));
    send(encode(12'h1A5));
    @(posedge clk);
    #1;
    check("full_in_ready", int'(bus.in_ready), 0);
    check("full_out_valid", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_err_cnt", int'(err_cnt), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_no_output", int'(bus.out_valid), 0);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    send(encode(12'h2C3));
    @(negedge clk);
    check("latency_cycle1_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("latency_cycle2_valid", int'(bus.out_valid), 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
